// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table (lit-high, bit0=a .. bit6=g) and digit types.
// Used by both the display encoder and this reader so the two ends always agree.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef struct packed {
        logic       err;
        logic [3:0] bcd;
    } digit_dec_t;

endpackage

// File: rtl/seg7_display_reader_if.sv
// Display-bus side and frame handshake of the 7-segment reader.
// master = the reader itself, slave = the environment (panel inputs + frame consumer).
interface seg7_display_reader_if;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic        scan_en;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        frame_valid;
    logic        frame_ready;
    logic [1:0]  scan_idx;

    modport master (
        input  hex0, hex1, hex2, hex3, scan_en, frame_ready,
        output bcd, err, frame_valid, scan_idx
    );

    modport slave (
        output hex0, hex1, hex2, hex3, scan_en, frame_ready,
        input  bcd, err, frame_valid, scan_idx
    );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational lit-high 7-segment pattern -> BCD digit; anything that is
// not an exact 0-9 glyph reads as BCD_INVALID with err set.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output digit_dec_t o_dec
);

    always_comb begin
        o_dec = '{err: 1'b0, bcd: 4'd0};
        case (i_pat)
            SEG_0:   o_dec.bcd = 4'd0;
            SEG_1:   o_dec.bcd = 4'd1;
            SEG_2:   o_dec.bcd = 4'd2;
            SEG_3:   o_dec.bcd = 4'd3;
            SEG_4:   o_dec.bcd = 4'd4;
            SEG_5:   o_dec.bcd = 4'd5;
            SEG_6:   o_dec.bcd = 4'd6;
            SEG_7:   o_dec.bcd = 4'd7;
            SEG_8:   o_dec.bcd = 4'd8;
            SEG_9:   o_dec.bcd = 4'd9;
            default: o_dec = '{err: 1'b1, bcd: BCD_INVALID};
        endcase
    end

endmodule

// File: rtl/seg7_display_reader.sv
// Scans four 7-segment inputs one digit per clock, debounces each digit and
// delivers decoded, stable frames over a valid/ready handshake.
//
//  state | meaning
//  SCAN  | watching for a stable frame that differs from the last one delivered
//  HOLD  | frame presented on bcd/err, waiting for frame_ready; scanning continues
module seg7_display_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seg7_display_reader_if.master        bus
);

    localparam int             CW      = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [1:0]    r_scan_idx;
    logic [6:0]    r_last_pat [NUM_DIGITS];
    logic [CW-1:0] r_cnt      [NUM_DIGITS];
    logic [0:0]    r_state;
    logic [15:0]   r_bcd;
    logic [3:0]    r_err;
    logic          r_frame_valid;
    logic          r_delivered;

    logic [6:0]    w_hex [NUM_DIGITS];
    logic [6:0]    w_pat;
    logic          w_match;
    logic [CW-1:0] w_cnt_upd;
    logic          w_all_stable;
    logic          w_cand_vld;
    logic [15:0]   w_cand_bcd;
    logic [3:0]    w_cand_err;
    digit_dec_t    w_dec [NUM_DIGITS];

    assign w_hex[0] = bus.hex0;
    assign w_hex[1] = bus.hex1;
    assign w_hex[2] = bus.hex2;
    assign w_hex[3] = bus.hex3;

    assign w_pat     = ACTIVE_LOW ? ~w_hex[r_scan_idx] : w_hex[r_scan_idx];
    assign w_match   = (w_pat == r_last_pat[r_scan_idx]);
    assign w_cnt_upd = !w_match ? '0 :
                       (r_cnt[r_scan_idx] == CNT_MAX) ? CNT_MAX :
                       r_cnt[r_scan_idx] + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_idx <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_last_pat[i] <= 7'd0;
                r_cnt[i]      <= '0;
            end
        end else if (bus.scan_en) begin
            r_last_pat[r_scan_idx] <= w_pat;
            r_cnt[r_scan_idx]      <= w_cnt_upd;
            r_scan_idx             <= r_scan_idx + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_digit_decode u_dec (
            .i_pat (r_last_pat[g]),
            .o_dec (w_dec[g])
        );
    end

    // The digit sampled this cycle contributes its post-update count; once it
    // reaches CNT_MAX its stored pattern already equals the sample, so decoding
    // the registered pattern is safe.
    always_comb begin
        w_all_stable = 1'b1;
        w_cand_bcd   = 16'd0;
        w_cand_err   = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (2'(i) == r_scan_idx) begin
                if (w_cnt_upd != CNT_MAX) w_all_stable = 1'b0;
            end else if (r_cnt[i] != CNT_MAX) begin
                w_all_stable = 1'b0;
            end
            w_cand_bcd[4*i +: 4] = w_dec[i].bcd;
            w_cand_err[i]        = w_dec[i].err;
        end
        w_cand_vld = bus.scan_en && (r_scan_idx == 2'd3) && w_all_stable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SCAN;
            r_bcd         <= 16'h0000;
            r_err         <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_delivered   <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_cand_vld &&
                        (({r_err, r_bcd} != {w_cand_err, w_cand_bcd}) || !r_delivered)) begin
                        r_bcd         <= w_cand_bcd;
                        r_err         <= w_cand_err;
                        r_frame_valid <= 1'b1;
                        r_delivered   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_frame_valid && bus.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= ST_SCAN;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign bus.bcd         = r_bcd;
    assign bus.err         = r_err;
    assign bus.frame_valid = r_frame_valid;
    assign bus.scan_idx    = r_scan_idx;

endmodule
